// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode constants, instruction-register field layout
// and the fetch-state encoding used by the fetch unit.
package sisc_pkg;

  localparam logic [3:0]  OP_NOOP  = 4'd0;
  localparam logic [3:0]  OP_HLT   = 4'd15;
  localparam logic [31:0] HLT_WORD = 32'hF000_0000;

  localparam int IR_OPC_LSB = 28;
  localparam int IR_OPC_W   = 4;
  localparam int IR_MM_LSB  = 24;
  localparam int IR_MM_W    = 4;
  localparam int IR_IMM_LSB = 0;
  localparam int IR_IMM_W   = 16;

  typedef enum logic [0:0] {
    FS_IDLE = 1'b0,
    FS_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface sisc_fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/sisc_next_pc.sv
// Next-PC selection: PC+1, absolute immediate, or PC+1+sext(imm), all modulo 2^AW.
module sisc_next_pc #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] pc_i,
  input  logic [15:0]   imm_i,
  input  logic          pc_sel_i,
  input  logic          br_sel_i,
  output logic [AW-1:0] next_pc_o
);

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] imm_sext_s;
  logic [AW-1:0] imm_zext_s;

  assign pc_inc_s   = pc_i + PC_ONE;
  assign imm_sext_s = AW'($signed(imm_i));
  assign imm_zext_s = AW'(imm_i);

  // Select sequential, absolute or relative successor
  always_comb begin
    next_pc_o = pc_inc_s;
    if (!pc_sel_i) begin
      next_pc_o = pc_inc_s;
    end else if (br_sel_i) begin
      next_pc_o = pc_inc_s + imm_sext_s;
    end else begin
      next_pc_o = imm_zext_s;
    end
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC program counter and instruction register with a req/ack instruction fetch,
// fetch timeout (loads HLT and raises a sticky error) and pc_rst fetch abort.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
  parameter int            TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pc_rst_i,
  input  logic                    pc_write_i,
  input  logic                    pc_sel_i,
  input  logic                    br_sel_i,
  input  logic                    ir_load_i,
  sisc_fetch_unit_if.master       imem,
  output logic                    if_busy_o,
  output logic                    imem_err_o,
  output logic [AW-1:0]           pc_o,
  output logic [DW-1:0]           ir_o,
  output logic [IR_OPC_W-1:0]     opcode_o,
  output logic [IR_MM_W-1:0]      mm_o,
  output logic [IR_IMM_W-1:0]     imm_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_e  state_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] ir_q;
  logic          busy_q;
  logic          err_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  sisc_next_pc #(
    .AW (AW)
  ) u_next_pc (
    .pc_i      (pc_q),
    .imm_i     (ir_q[IR_IMM_LSB +: IR_IMM_W]),
    .pc_sel_i  (pc_sel_i),
    .br_sel_i  (br_sel_i),
    .next_pc_o (pc_d)
  );

  // Fetch FSM: request issue, ack capture, timeout fault and pc_rst abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= {AW{1'b0}};
      ir_q    <= {DW{1'b0}};
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (ir_load_i) begin
            state_q <= FS_REQ;
            busy_q  <= 1'b1;
            addr_q  <= pc_q;
            cnt_q   <= 8'd0;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        FS_REQ: begin
          // An abort wins over a same-cycle ack so the IR keeps its old word
          if (pc_rst_i) begin
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
          end else if (imem.imem_ack) begin
            ir_q    <= imem.imem_rdata;
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            ir_q    <= DW'(HLT_WORD);
            err_q   <= 1'b1;
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Program counter: pc_rst over pc_write over hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_rst_i) begin
      pc_q <= RESET_PC;
    end else if (pc_write_i) begin
      pc_q <= pc_d;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign imem.imem_req  = busy_q;
  assign imem.imem_addr = addr_q;
  assign if_busy_o      = busy_q;
  assign imem_err_o     = err_q;
  assign pc_o           = pc_q;
  assign ir_o           = ir_q;
  assign opcode_o       = ir_q[IR_OPC_LSB +: IR_OPC_W];
  assign mm_o           = ir_q[IR_MM_LSB +: IR_MM_W];
  assign imm_o          = ir_q[IR_IMM_LSB +: IR_IMM_W];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed self-checking bench for sisc_fetch_unit with hand-computed expectations.
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;
  logic        if_busy;
  logic        imem_err;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;

  int checks = 0;
  int errors = 0;

  sisc_fetch_unit_if #(.AW(16), .DW(32)) imem_bus ();

  sisc_fetch_unit #(
    .AW       (16),
    .DW       (32),
    .RESET_PC (16'h0000),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_rst_i   (pc_rst),
    .pc_write_i (pc_write),
    .pc_sel_i   (pc_sel),
    .br_sel_i   (br_sel),
    .ir_load_i  (ir_load),
    .imem       (imem_bus.master),
    .if_busy_o  (if_busy),
    .imem_err_o (imem_err),
    .pc_o       (pc),
    .ir_o       (ir),
    .opcode_o   (opcode),
    .mm_o       (mm),
    .imm_o      (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    imem_bus.imem_rdata = word;
    imem_bus.imem_ack   = 1'b1;
    tick();
    imem_bus.imem_ack   = 1'b0;
  endtask

  task automatic do_pc_write(input logic sel, input logic bsel);
    pc_sel   = sel;
    br_sel   = bsel;
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 00000000", ir); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_bus.imem_addr); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if_busy); end
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", imem_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int rc;
    rc = 0;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    checks++; if (imem_bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch_addr: got %h want 0000", imem_bus.imem_addr); end
    imem_bus.imem_rdata = 32'h8812_0003;
    for (int i = 0; i < 3; i++) begin
      if (imem_bus.imem_req === 1'b1) rc++;
      if (i == 2) imem_bus.imem_ack = 1'b1;
      tick();
    end
    imem_bus.imem_ack = 1'b0;
    checks++; if (rc !== 3) begin errors++; $display("FAIL fetch_req_cycles: got %0d want 3", rc); end
    checks++; if (ir !== 32'h8812_0003) begin errors++; $display("FAIL fetch_ir: got %h want 88120003", ir); end
    checks++; if (opcode !== 4'd8) begin errors++; $display("FAIL fetch_opcode: got %h want 8", opcode); end
    checks++; if (mm !== 4'd8) begin errors++; $display("FAIL fetch_mm: got %h want 8", mm); end
    checks++; if (imm !== 16'h0003) begin errors++; $display("FAIL fetch_imm: got %h want 0003", imm); end
    checks++; if (if_busy !== 1'b0 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL fetch_done: busy %b req %b want 0 0", if_busy, imem_bus.imem_req); end
  endtask

  task automatic test_next_pc();
    do_fetch(32'h1000_0010);
    do_pc_write(1'b1, 1'b0);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL npc_abs_setup: got %h want 0010", pc); end
    do_fetch(32'h1000_FFFC);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL npc_fetch_hold: got %h want 0010", pc); end
    do_pc_write(1'b1, 1'b1);
    checks++; if (pc !== 16'h000D) begin errors++; $display("FAIL npc_rel_neg: got %h want 000d", pc); end
    do_pc_write(1'b1, 1'b0);
    checks++; if (pc !== 16'hFFFC) begin errors++; $display("FAIL npc_abs: got %h want fffc", pc); end
    do_fetch(32'h1000_FFFF);
    do_pc_write(1'b1, 1'b0);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL npc_abs_ffff: got %h want ffff", pc); end
    do_pc_write(1'b0, 1'b0);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL npc_wrap: got %h want 0000", pc); end
    do_pc_write(1'b1, 1'b1);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL npc_rel_minus1: got %h want 0000", pc); end
  endtask

  task automatic test_timeout();
    int rc;
    rc = 0;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    for (int i = 0; i < 40 && imem_bus.imem_req === 1'b1; i++) begin
      rc++;
      if (rc == 15) begin
        checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early: got %b want 0", imem_err); end
      end
      tick();
    end
    checks++; if (rc !== 15) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 15", rc); end
    checks++; if (ir !== 32'hF000_0000) begin errors++; $display("FAIL timeout_ir: got %h want f0000000", ir); end
    checks++; if (opcode !== 4'hF) begin errors++; $display("FAIL timeout_opcode: got %h want f", opcode); end
    checks++; if (imem_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", imem_err); end
    do_fetch(32'h1234_5678);
    checks++; if (imem_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b want 1", imem_err); end
  endtask

  task automatic test_abort();
    do_pc_write(1'b0, 1'b0);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL abort_setup_pc: got %h want 0001", pc); end
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    tick();
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    checks++; if (if_busy !== 1'b0 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b req %b want 0 0", if_busy, imem_bus.imem_req); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL abort_pc: got %h want 0000", pc); end
    checks++; if (ir !== 32'h1234_5678) begin errors++; $display("FAIL abort_ir: got %h want 12345678", ir); end
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    imem_bus.imem_ack   = 1'b1;
    tick();
    imem_bus.imem_ack   = 1'b0;
    checks++; if (ir !== 32'h1234_5678) begin errors++; $display("FAIL abort_late_ack_ir: got %h want 12345678", ir); end
    checks++; if (imem_err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", imem_err); end
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h2000_0005);
    do_pc_write(1'b1, 1'b0);
    checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL b2b_setup_pc: got %h want 0005", pc); end
    ir_load  = 1'b1;
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    tick();
    pc_write = 1'b0;
    checks++; if (imem_bus.imem_addr !== 16'h0005) begin errors++; $display("FAIL b2b_addr: got %h want 0005", imem_bus.imem_addr); end
    checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL b2b_pc: got %h want 0006", pc); end
    tick();
    ir_load = 1'b0;
    checks++; if (imem_bus.imem_addr !== 16'h0005 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL b2b_busy_load: addr %h req %b want 0005 1", imem_bus.imem_addr, imem_bus.imem_req); end
    imem_bus.imem_rdata = 32'h3300_0042;
    imem_bus.imem_ack   = 1'b1;
    tick();
    imem_bus.imem_ack   = 1'b0;
    checks++; if (ir !== 32'h3300_0042 || if_busy !== 1'b0) begin errors++; $display("FAIL b2b_ir: ir %h busy %b want 33000042 0", ir, if_busy); end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_rerequest: got %b want 0", imem_bus.imem_req); end
  endtask

  task automatic test_async_reset();
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0 || if_busy !== 1'b0) begin errors++; $display("FAIL arst_req: req %b busy %b want 0 0", imem_bus.imem_req, if_busy); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL arst_pc: got %h want 0000", pc); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL arst_ir: got %h want 00000000", ir); end
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", imem_err); end
    checks++; if (imem_bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL arst_addr: got %h want 0000", imem_bus.imem_addr); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (if_busy !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL arst_release: busy %b pc %h want 0 0000", if_busy, pc); end
  endtask

  initial begin
    rst                 = 1'b1;
    pc_rst              = 1'b0;
    pc_write            = 1'b0;
    pc_sel              = 1'b0;
    br_sel              = 1'b0;
    ir_load             = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_next_pc();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
